// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage of the SIMD AES pipeline.
// Defines the scalar/vector opcode enums, the FSM state enum, the operand hold
// buffer and MEM_* payload structs, and the GF(2^8) xtime helper.
package ex_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned LANES      = 4;
  localparam int unsigned LANE_W     = 8;
  localparam int unsigned LANE_IDX_W = 2;
  localparam int unsigned REG_W      = 5;

  localparam logic [7:0]            AES_POLY  = 8'h1B;
  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

  typedef enum logic [1:0] {ADD, SUB, AND, OR} alu_op_t;
  typedef enum logic [1:0] {VXOR, VSUB, VXTIME, VROT} vec_op_t;
  typedef enum logic {IDLE, BUSY} ex_state_t;

  // Vector operands and controls captured when a vector op is accepted
  typedef struct packed {
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [XLEN-1:0]  wdata;
    logic [REG_W-1:0] rd;
    logic [1:0]       ctrl;
    logic [1:0]       mem_to_reg;
    logic             reg_write;
    logic             mem_write;
  } hold_t;

  // Registered payload toward the memory stage
  typedef struct packed {
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  write_data;
    logic [REG_W-1:0] rd;
    logic [1:0]       mem_to_reg;
    logic             reg_write;
    logic             mem_write;
    logic             vreg_write;
  } mem_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box as a combinational 256-entry case ROM.
// Only instantiated when EX_SBOX_EN is defined.
// Ports: a_i (8-bit input byte), y_o (8-bit substituted byte).
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  always_comb begin
    y_o = 8'h00;
    case (a_i)
      8'h00: y_o = 8'h63; 8'h01: y_o = 8'h7c; 8'h02: y_o = 8'h77; 8'h03: y_o = 8'h7b; 8'h04: y_o = 8'hf2; 8'h05: y_o = 8'h6b; 8'h06: y_o = 8'h6f; 8'h07: y_o = 8'hc5;
      8'h08: y_o = 8'h30; 8'h09: y_o = 8'h01; 8'h0a: y_o = 8'h67; 8'h0b: y_o = 8'h2b; 8'h0c: y_o = 8'hfe; 8'h0d: y_o = 8'hd7; 8'h0e: y_o = 8'hab; 8'h0f: y_o = 8'h76;
      8'h10: y_o = 8'hca; 8'h11: y_o = 8'h82; 8'h12: y_o = 8'hc9; 8'h13: y_o = 8'h7d; 8'h14: y_o = 8'hfa; 8'h15: y_o = 8'h59; 8'h16: y_o = 8'h47; 8'h17: y_o = 8'hf0;
      8'h18: y_o = 8'had; 8'h19: y_o = 8'hd4; 8'h1a: y_o = 8'ha2; 8'h1b: y_o = 8'haf; 8'h1c: y_o = 8'h9c; 8'h1d: y_o = 8'ha4; 8'h1e: y_o = 8'h72; 8'h1f: y_o = 8'hc0;
      8'h20: y_o = 8'hb7; 8'h21: y_o = 8'hfd; 8'h22: y_o = 8'h93; 8'h23: y_o = 8'h26; 8'h24: y_o = 8'h36; 8'h25: y_o = 8'h3f; 8'h26: y_o = 8'hf7; 8'h27: y_o = 8'hcc;
      8'h28: y_o = 8'h34; 8'h29: y_o = 8'ha5; 8'h2a: y_o = 8'he5; 8'h2b: y_o = 8'hf1; 8'h2c: y_o = 8'h71; 8'h2d: y_o = 8'hd8; 8'h2e: y_o = 8'h31; 8'h2f: y_o = 8'h15;
      8'h30: y_o = 8'h04; 8'h31: y_o = 8'hc7; 8'h32: y_o = 8'h23; 8'h33: y_o = 8'hc3; 8'h34: y_o = 8'h18; 8'h35: y_o = 8'h96; 8'h36: y_o = 8'h05; 8'h37: y_o = 8'h9a;
      8'h38: y_o = 8'h07; 8'h39: y_o = 8'h12; 8'h3a: y_o = 8'h80; 8'h3b: y_o = 8'he2; 8'h3c: y_o = 8'heb; 8'h3d: y_o = 8'h27; 8'h3e: y_o = 8'hb2; 8'h3f: y_o = 8'h75;
      8'h40: y_o = 8'h09; 8'h41: y_o = 8'h83; 8'h42: y_o = 8'h2c; 8'h43: y_o = 8'h1a; 8'h44: y_o = 8'h1b; 8'h45: y_o = 8'h6e; 8'h46: y_o = 8'h5a; 8'h47: y_o = 8'ha0;
      8'h48: y_o = 8'h52; 8'h49: y_o = 8'h3b; 8'h4a: y_o = 8'hd6; 8'h4b: y_o = 8'hb3; 8'h4c: y_o = 8'h29; 8'h4d: y_o = 8'he3; 8'h4e: y_o = 8'h2f; 8'h4f: y_o = 8'h84;
      8'h50: y_o = 8'h53; 8'h51: y_o = 8'hd1; 8'h52: y_o = 8'h00; 8'h53: y_o = 8'hed; 8'h54: y_o = 8'h20; 8'h55: y_o = 8'hfc; 8'h56: y_o = 8'hb1; 8'h57: y_o = 8'h5b;
      8'h58: y_o = 8'h6a; 8'h59: y_o = 8'hcb; 8'h5a: y_o = 8'hbe; 8'h5b: y_o = 8'h39; 8'h5c: y_o = 8'h4a; 8'h5d: y_o = 8'h4c; 8'h5e: y_o = 8'h58; 8'h5f: y_o = 8'hcf;
      8'h60: y_o = 8'hd0; 8'h61: y_o = 8'hef; 8'h62: y_o = 8'haa; 8'h63: y_o = 8'hfb; 8'h64: y_o = 8'h43; 8'h65: y_o = 8'h4d; 8'h66: y_o = 8'h33; 8'h67: y_o = 8'h85;
      8'h68: y_o = 8'h45; 8'h69: y_o = 8'hf9; 8'h6a: y_o = 8'h02; 8'h6b: y_o = 8'h7f; 8'h6c: y_o = 8'h50; 8'h6d: y_o = 8'h3c; 8'h6e: y_o = 8'h9f; 8'h6f: y_o = 8'ha8;
      8'h70: y_o = 8'h51; 8'h71: y_o = 8'ha3; 8'h72: y_o = 8'h40; 8'h73: y_o = 8'h8f; 8'h74: y_o = 8'h92; 8'h75: y_o = 8'h9d; 8'h76: y_o = 8'h38; 8'h77: y_o = 8'hf5;
      8'h78: y_o = 8'hbc; 8'h79: y_o = 8'hb6; 8'h7a: y_o = 8'hda; 8'h7b: y_o = 8'h21; 8'h7c: y_o = 8'h10; 8'h7d: y_o = 8'hff; 8'h7e: y_o = 8'hf3; 8'h7f: y_o = 8'hd2;
      8'h80: y_o = 8'hcd; 8'h81: y_o = 8'h0c; 8'h82: y_o = 8'h13; 8'h83: y_o = 8'hec; 8'h84: y_o = 8'h5f; 8'h85: y_o = 8'h97; 8'h86: y_o = 8'h44; 8'h87: y_o = 8'h17;
      8'h88: y_o = 8'hc4; 8'h89: y_o = 8'ha7; 8'h8a: y_o = 8'h7e; 8'h8b: y_o = 8'h3d; 8'h8c: y_o = 8'h64; 8'h8d: y_o = 8'h5d; 8'h8e: y_o = 8'h19; 8'h8f: y_o = 8'h73;
      8'h90: y_o = 8'h60; 8'h91: y_o = 8'h81; 8'h92: y_o = 8'h4f; 8'h93: y_o = 8'hdc; 8'h94: y_o = 8'h22; 8'h95: y_o = 8'h2a; 8'h96: y_o = 8'h90; 8'h97: y_o = 8'h88;
      8'h98: y_o = 8'h46; 8'h99: y_o = 8'hee; 8'h9a: y_o = 8'hb8; 8'h9b: y_o = 8'h14; 8'h9c: y_o = 8'hde; 8'h9d: y_o = 8'h5e; 8'h9e: y_o = 8'h0b; 8'h9f: y_o = 8'hdb;
      8'ha0: y_o = 8'he0; 8'ha1: y_o = 8'h32; 8'ha2: y_o = 8'h3a; 8'ha3: y_o = 8'h0a; 8'ha4: y_o = 8'h49; 8'ha5: y_o = 8'h06; 8'ha6: y_o = 8'h24; 8'ha7: y_o = 8'h5c;
      8'ha8: y_o = 8'hc2; 8'ha9: y_o = 8'hd3; 8'haa: y_o = 8'hac; 8'hab: y_o = 8'h62; 8'hac: y_o = 8'h91; 8'had: y_o = 8'h95; 8'hae: y_o = 8'he4; 8'haf: y_o = 8'h79;
      8'hb0: y_o = 8'he7; 8'hb1: y_o = 8'hc8; 8'hb2: y_o = 8'h37; 8'hb3: y_o = 8'h6d; 8'hb4: y_o = 8'h8d; 8'hb5: y_o = 8'hd5; 8'hb6: y_o = 8'h4e; 8'hb7: y_o = 8'ha9;
      8'hb8: y_o = 8'h6c; 8'hb9: y_o = 8'h56; 8'hba: y_o = 8'hf4; 8'hbb: y_o = 8'hea; 8'hbc: y_o = 8'h65; 8'hbd: y_o = 8'h7a; 8'hbe: y_o = 8'hae; 8'hbf: y_o = 8'h08;
      8'hc0: y_o = 8'hba; 8'hc1: y_o = 8'h78; 8'hc2: y_o = 8'h25; 8'hc3: y_o = 8'h2e; 8'hc4: y_o = 8'h1c; 8'hc5: y_o = 8'ha6; 8'hc6: y_o = 8'hb4; 8'hc7: y_o = 8'hc6;
      8'hc8: y_o = 8'he8; 8'hc9: y_o = 8'hdd; 8'hca: y_o = 8'h74; 8'hcb: y_o = 8'h1f; 8'hcc: y_o = 8'h4b; 8'hcd: y_o = 8'hbd; 8'hce: y_o = 8'h8b; 8'hcf: y_o = 8'h8a;
      8'hd0: y_o = 8'h70; 8'hd1: y_o = 8'h3e; 8'hd2: y_o = 8'hb5; 8'hd3: y_o = 8'h66; 8'hd4: y_o = 8'h48; 8'hd5: y_o = 8'h03; 8'hd6: y_o = 8'hf6; 8'hd7: y_o = 8'h0e;
      8'hd8: y_o = 8'h61; 8'hd9: y_o = 8'h35; 8'hda: y_o = 8'h57; 8'hdb: y_o = 8'hb9; 8'hdc: y_o = 8'h86; 8'hdd: y_o = 8'hc1; 8'hde: y_o = 8'h1d; 8'hdf: y_o = 8'h9e;
      8'he0: y_o = 8'he1; 8'he1: y_o = 8'hf8; 8'he2: y_o = 8'h98; 8'he3: y_o = 8'h11; 8'he4: y_o = 8'h69; 8'he5: y_o = 8'hd9; 8'he6: y_o = 8'h8e; 8'he7: y_o = 8'h94;
      8'he8: y_o = 8'h9b; 8'he9: y_o = 8'h1e; 8'hea: y_o = 8'h87; 8'heb: y_o = 8'he9; 8'hec: y_o = 8'hce; 8'hed: y_o = 8'h55; 8'hee: y_o = 8'h28; 8'hef: y_o = 8'hdf;
      8'hf0: y_o = 8'h8c; 8'hf1: y_o = 8'ha1; 8'hf2: y_o = 8'h89; 8'hf3: y_o = 8'h0d; 8'hf4: y_o = 8'hbf; 8'hf5: y_o = 8'he6; 8'hf6: y_o = 8'h42; 8'hf7: y_o = 8'h68;
      8'hf8: y_o = 8'h41; 8'hf9: y_o = 8'h99; 8'hfa: y_o = 8'h2d; 8'hfb: y_o = 8'h0f; 8'hfc: y_o = 8'hb0; 8'hfd: y_o = 8'h54; 8'hfe: y_o = 8'hbb; 8'hff: y_o = 8'h16;
      default: y_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the SIMD AES pipeline. Scalar ALU ops finish in one cycle;
// vector byte-lane ops run lane-serially over four cycles while stall holds
// the upstream stages.
// Ports: clk, rst (sync, active-high); EX_* operands/controls from ID/EX;
// MEM_* registered result/controls to MEM; stall (combinational) to upstream.
// Config: define EX_SBOX_EN to build the S-box ROM for vector op 01;
// otherwise op 01 copies the lane unchanged.
module ex_stage
  import ex_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  EX_data1,
  input  logic [XLEN-1:0]  EX_data2,
  input  logic [XLEN-1:0]  EX_Imm,
  input  logic [REG_W-1:0] EX_rd,
  input  logic [1:0]       EX_ALUControl,
  input  logic             EX_ALUScr,
  input  logic             EX_RegWrite,
  input  logic             EX_MemWrite,
  input  logic             EX_VRegWrite,
  input  logic [1:0]       EX_MemToReg,
  output logic [XLEN-1:0]  MEM_ALUResult,
  output logic [XLEN-1:0]  MEM_WriteData,
  output logic [REG_W-1:0] MEM_rd,
  output logic [1:0]       MEM_MemToReg,
  output logic             MEM_RegWrite,
  output logic             MEM_MemWrite,
  output logic             MEM_VRegWrite,
  output logic             stall
);

  ex_state_t             state_q, state_d;
  logic [LANE_IDX_W-1:0] lane_q, lane_d, lane_nxt;
  hold_t                 hold_q, hold_d;
  logic [XLEN-1:0]       res_q, res_d;
  mem_t                  mem_q, mem_d;

  logic [XLEN-1:0]   b_sel, alu_res;
  logic [LANE_W-1:0] lane_a, lane_b, rot_a, sbox_y, lane_res;

  assign b_sel    = EX_ALUScr ? EX_Imm : EX_data2;
  assign lane_nxt = lane_q + LANE_IDX_W'(1);

  // Scalar ALU
  always_comb begin
    alu_res = '0;
    case (alu_op_t'(EX_ALUControl))
      ADD:     alu_res = EX_data1 + b_sel;
      SUB:     alu_res = EX_data1 - b_sel;
      AND:     alu_res = EX_data1 & b_sel;
      OR:      alu_res = EX_data1 | b_sel;
      default: alu_res = '0;
    endcase
  end

  // Current lane operands; RotWord reads the next lane up, wrapping 3 -> 0
  assign lane_a = hold_q.a[{lane_q, 3'b000} +: LANE_W];
  assign lane_b = hold_q.b[{lane_q, 3'b000} +: LANE_W];
  assign rot_a  = hold_q.a[{lane_nxt, 3'b000} +: LANE_W];

`ifdef EX_SBOX_EN
  aes_sbox u_sbox (
    .a_i (lane_a),
    .y_o (sbox_y)
  );
`else
  assign sbox_y = lane_a;
`endif

  // Single shared byte-lane datapath
  always_comb begin
    lane_res = '0;
    case (vec_op_t'(hold_q.ctrl))
      VXOR:    lane_res = lane_a ^ lane_b;
      VSUB:    lane_res = sbox_y;
      VXTIME:  lane_res = xtime(lane_a);
      VROT:    lane_res = rot_a;
      default: lane_res = '0;
    endcase
  end

  assign stall = ~rst & (((state_q == IDLE) & EX_VRegWrite) |
                         ((state_q == BUSY) & (lane_q != LAST_LANE)));

  // Next-state / output logic; MEM_* default to a bubble every cycle
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    hold_d  = hold_q;
    res_d   = res_q;
    mem_d   = '0;
    case (state_q)
      IDLE: begin
        if (EX_VRegWrite) begin
          hold_d.a          = EX_data1;
          hold_d.b          = b_sel;
          hold_d.wdata      = EX_data2;
          hold_d.rd         = EX_rd;
          hold_d.ctrl       = EX_ALUControl;
          hold_d.mem_to_reg = EX_MemToReg;
          hold_d.reg_write  = EX_RegWrite;
          hold_d.mem_write  = EX_MemWrite;
          res_d             = '0;
          lane_d            = '0;
          state_d           = BUSY;
        end else begin
          mem_d.alu_result = alu_res;
          mem_d.write_data = EX_data2;
          mem_d.rd         = EX_rd;
          mem_d.mem_to_reg = EX_MemToReg;
          mem_d.reg_write  = EX_RegWrite;
          mem_d.mem_write  = EX_MemWrite;
          mem_d.vreg_write = 1'b0;
        end
      end
      BUSY: begin
        res_d[{lane_q, 3'b000} +: LANE_W] = lane_res;
        lane_d = lane_nxt;
        if (lane_q == LAST_LANE) begin
          mem_d.alu_result = res_d;
          mem_d.write_data = hold_q.wdata;
          mem_d.rd         = hold_q.rd;
          mem_d.mem_to_reg = hold_q.mem_to_reg;
          mem_d.reg_write  = hold_q.reg_write;
          mem_d.mem_write  = hold_q.mem_write;
          mem_d.vreg_write = 1'b1;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      hold_q  <= '0;
      res_q   <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      hold_q  <= hold_d;
      res_q   <= res_d;
      mem_q   <= mem_d;
    end
  end

  assign MEM_ALUResult = mem_q.alu_result;
  assign MEM_WriteData = mem_q.write_data;
  assign MEM_rd        = mem_q.rd;
  assign MEM_MemToReg  = mem_q.mem_to_reg;
  assign MEM_RegWrite  = mem_q.reg_write;
  assign MEM_MemWrite  = mem_q.mem_write;
  assign MEM_VRegWrite = mem_q.vreg_write;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: scalar ops, the four vector ops,
// bubbles during a vector op, vector-then-scalar hand-off, back-to-back
// vector ops, and reset in the middle of a vector op.
module tb_ex_stage;

  logic        clk;
  logic        rst;
  logic [31:0] EX_data1, EX_data2, EX_Imm;
  logic [4:0]  EX_rd;
  logic [1:0]  EX_ALUControl;
  logic        EX_ALUScr, EX_RegWrite, EX_MemWrite, EX_VRegWrite;
  logic [1:0]  EX_MemToReg;
  logic [31:0] MEM_ALUResult, MEM_WriteData;
  logic [4:0]  MEM_rd;
  logic [1:0]  MEM_MemToReg;
  logic        MEM_RegWrite, MEM_MemWrite, MEM_VRegWrite;
  logic        stall;

  int errors = 0;
  int checks = 0;

  ex_stage dut (
    .clk           (clk),
    .rst           (rst),
    .EX_data1      (EX_data1),
    .EX_data2      (EX_data2),
    .EX_Imm        (EX_Imm),
    .EX_rd         (EX_rd),
    .EX_ALUControl (EX_ALUControl),
    .EX_ALUScr     (EX_ALUScr),
    .EX_RegWrite   (EX_RegWrite),
    .EX_MemWrite   (EX_MemWrite),
    .EX_VRegWrite  (EX_VRegWrite),
    .EX_MemToReg   (EX_MemToReg),
    .MEM_ALUResult (MEM_ALUResult),
    .MEM_WriteData (MEM_WriteData),
    .MEM_rd        (MEM_rd),
    .MEM_MemToReg  (MEM_MemToReg),
    .MEM_RegWrite  (MEM_RegWrite),
    .MEM_MemWrite  (MEM_MemWrite),
    .MEM_VRegWrite (MEM_VRegWrite),
    .stall         (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [4:0] rd, input logic [1:0] op, input logic scr,
                       input logic rw, input logic mw, input logic vw, input logic [1:0] mtr);
    EX_data1      = a;
    EX_data2      = d2;
    EX_Imm        = imm;
    EX_rd         = rd;
    EX_ALUControl = op;
    EX_ALUScr     = scr;
    EX_RegWrite   = rw;
    EX_MemWrite   = mw;
    EX_VRegWrite  = vw;
    EX_MemToReg   = mtr;
  endtask

  task automatic bubble();
    drive(32'h0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " alu"},   MEM_ALUResult, 32'h0);
    chk({tag, " wdata"}, MEM_WriteData, 32'h0);
    chk({tag, " rd"},    32'(MEM_rd), 32'h0);
    chk({tag, " m2r"},   32'(MEM_MemToReg), 32'h0);
    chk({tag, " ctl"},   32'({MEM_RegWrite, MEM_MemWrite, MEM_VRegWrite}), 32'h0);
  endtask

  // Presents a vector op in the current cycle (cycle 0) and holds it while
  // stalled; returns in cycle 5 with a bubble driven after checking results.
  task automatic vec_run(input string tag, input logic [31:0] a, input logic [31:0] d2,
                         input logic [31:0] imm, input logic scr, input logic [1:0] op,
                         input logic [31:0] exp);
    drive(a, d2, imm, 5'd9, op, scr, 1'b0, 1'b0, 1'b1, 2'b11);
    #1;
    chk({tag, " stall c0"}, 32'(stall), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("%s stall c%0d", tag, k), 32'(stall), 32'(k < 4));
      chk($sformatf("%s bubble alu c%0d", tag, k), MEM_ALUResult, 32'h0);
      chk($sformatf("%s bubble vw c%0d", tag, k), 32'({MEM_RegWrite, MEM_MemWrite, MEM_VRegWrite}), 32'h0);
    end
    step();
    bubble();
    chk({tag, " result"}, MEM_ALUResult, exp);
    chk({tag, " vw"},     32'(MEM_VRegWrite), 32'h1);
    chk({tag, " rd"},     32'(MEM_rd), 32'd9);
    chk({tag, " m2r"},    32'(MEM_MemToReg), 32'h3);
    chk({tag, " wdata"},  MEM_WriteData, d2);
  endtask

  initial begin
    logic [31:0] exp_sub;
`ifdef EX_SBOX_EN
    exp_sub = 32'hCA7CED63;
`else
    exp_sub = 32'h10015300;
`endif

    // Reset with a vector op presented: stall must stay low
    rst = 1'b1;
    drive(32'h12345678, 32'h1, 32'h2, 5'd7, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10);
    #1;
    chk("reset stall pre-edge", 32'(stall), 32'h0);
    step();
    step();
    chk("reset stall", 32'(stall), 32'h0);
    chk_outputs_zero("reset");
    rst = 1'b0;

    // Scalar ADD wraps modulo 2^32
    drive(32'hFFFFFFFF, 32'h2, 32'h0, 5'd3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
    #1;
    chk("add stall", 32'(stall), 32'h0);
    step();
    chk("add result", MEM_ALUResult, 32'h00000001);
    chk("add wdata",  MEM_WriteData, 32'h2);
    chk("add rd",     32'(MEM_rd), 32'd3);
    chk("add ctl",    32'({MEM_RegWrite, MEM_MemWrite, MEM_VRegWrite}), 32'b100);
    chk("add m2r",    32'(MEM_MemToReg), 32'h1);

    // Scalar SUB with immediate operand
    drive(32'h5, 32'h1234, 32'h7, 5'd17, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10);
    #1;
    chk("sub stall", 32'(stall), 32'h0);
    step();
    chk("sub result", MEM_ALUResult, 32'hFFFFFFFE);
    chk("sub wdata",  MEM_WriteData, 32'h1234);
    chk("sub rd",     32'(MEM_rd), 32'd17);
    chk("sub ctl",    32'({MEM_RegWrite, MEM_MemWrite, MEM_VRegWrite}), 32'b010);
    chk("sub m2r",    32'(MEM_MemToReg), 32'h2);

    // Scalar AND
    drive(32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0, 5'd2, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    step();
    chk("and result", MEM_ALUResult, 32'h00F0_1234);

    // Vector ops
    vec_run("vsub",   32'h10015300, 32'h0, 32'h0, 1'b0, 2'b01, exp_sub);
    vec_run("vxtime", 32'h83578301, 32'h0, 32'h0, 1'b0, 2'b10, 32'h1DAE1D02);
    // Back-to-back: ROT presented in cycle 5 of the XTIME op
    vec_run("vrot",   32'h44332211, 32'h0, 32'h0, 1'b0, 2'b11, 32'h11443322);

    // Vector XOR (B from immediate) followed directly by a scalar OR
    vec_run("vxor", 32'hA5A5A5A5, 32'hDEADBEEF, 32'h0F0F0F0F, 1'b1, 2'b00, 32'hAAAAAAAA);
    drive(32'hF0000000, 32'h0000000F, 32'h0, 5'd4, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    #1;
    chk("or stall", 32'(stall), 32'h0);
    step();
    bubble();
    chk("or result", MEM_ALUResult, 32'hF000000F);
    chk("or rd",     32'(MEM_rd), 32'd4);
    chk("or ctl",    32'({MEM_RegWrite, MEM_MemWrite, MEM_VRegWrite}), 32'b100);

    // Reset in cycle 2 of a vector op aborts it with no writeback
    drive(32'h01020304, 32'h55, 32'h0, 5'd12, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("midrst stall", 32'(stall), 32'h0);
    step();
    rst = 1'b0;
    bubble();
    #1;
    chk("midrst stall after", 32'(stall), 32'h0);
    chk_outputs_zero("midrst");
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("midrst no vw %0d", k), 32'(MEM_VRegWrite), 32'h0);
      chk($sformatf("midrst stall %0d", k), 32'(stall), 32'h0);
    end
    vec_run("post-rst vrot", 32'hDDCCBBAA, 32'h0, 32'h0, 1'b0, 2'b11, 32'hAADDCCBB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
